// File: rtl/ysyx_23060025_clint_pkg.sv
// Shared CLINT constants: mtime register offsets and responder FSM states.
// Imported by the interface, the mtime counter and the top-level responder.
package ysyx_23060025_clint_pkg;

    localparam int          CLINT_ADDR_LEN     = 32;
    localparam int          CLINT_DATA_LEN     = 32;
    localparam logic [15:0] CLINT_MTIME_LO_OFF = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF = 16'hBFFC;

    typedef enum logic {
        CLINT_IDLE = 1'b0,
        CLINT_RESP = 1'b1
    } clint_state_e;

endpackage

// File: rtl/ysyx_23060025_clint_if.sv
// Read-address / read-data channel between the crossbar and the CLINT.
// Signal names keep the crossbar's port naming so wiring stays one-to-one.
interface ysyx_23060025_clint_if
    import ysyx_23060025_clint_pkg::*;
#(
    parameter int ADDR_LEN = CLINT_ADDR_LEN,
    parameter int DATA_LEN = CLINT_DATA_LEN
);

    logic [ADDR_LEN-1:0] clint_addr_r_addr_i;
    logic                clint_addr_r_valid_i;
    logic                clint_addr_r_ready_o;
    logic [DATA_LEN-1:0] clint_r_data_o;
    logic                clint_r_valid_o;
    logic                clint_r_last_o;
    logic                clint_r_ready_i;

    modport master (
        output clint_addr_r_addr_i,
        output clint_addr_r_valid_i,
        input  clint_addr_r_ready_o,
        input  clint_r_data_o,
        input  clint_r_valid_o,
        input  clint_r_last_o,
        output clint_r_ready_i
    );

    modport slave (
        input  clint_addr_r_addr_i,
        input  clint_addr_r_valid_i,
        output clint_addr_r_ready_o,
        output clint_r_data_o,
        output clint_r_valid_o,
        output clint_r_last_o,
        input  clint_r_ready_i
    );

endinterface

// File: rtl/ysyx_23060025_clint_mtime.sv
// Free-running 64-bit mtime with a clock prescaler of TICK_DIV core cycles.
// Counts regardless of bus activity; wraps naturally at 2^64.
module ysyx_23060025_clint_mtime #(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] o_mtime
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [63:0]   r_mtime;
    logic          w_tick;

    assign w_tick  = (r_pre == PRE_MAX);
    assign o_mtime = r_mtime;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060025_clint.sv
// Read-only CLINT responder: answers single-beat loads of mtime lo/hi.
// A lo read latches the high word so a following hi read is tear-free.
module ysyx_23060025_clint
    import ysyx_23060025_clint_pkg::*;
#(
    parameter int          ADDR_LEN     = CLINT_ADDR_LEN,
    parameter int          DATA_LEN     = CLINT_DATA_LEN,
    parameter logic [15:0] MTIME_LO_OFF = CLINT_MTIME_LO_OFF,
    parameter logic [15:0] MTIME_HI_OFF = CLINT_MTIME_HI_OFF,
    parameter int          TICK_DIV     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_23060025_clint_if.slave  bus
);

    clint_state_e        r_state;
    clint_state_e        w_state_nxt;
    logic [DATA_LEN-1:0] r_rdata;
    logic [DATA_LEN-1:0] w_rdata;
    logic [31:0]         r_shadow_hi;
    logic [31:0]         w_shadow_hi_nxt;
    logic                r_shadow_vld;
    logic                w_shadow_vld_nxt;
    logic [63:0]         w_mtime;
    logic [ADDR_LEN-1:0] w_addr;
    logic [15:0]         w_off;
    logic                w_ar_ready;
    logic                w_r_valid;
    logic                w_ar_fire;
    logic                w_unused_addr;

    ysyx_23060025_clint_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clock   (clock),
        .reset   (reset),
        .o_mtime (w_mtime)
    );

    // The crossbar already selected this device; only the low offset matters.
    assign w_addr        = bus.clint_addr_r_addr_i;
    assign w_off         = w_addr[15:0];
    assign w_unused_addr = ^w_addr[ADDR_LEN-1:16];
    assign w_ar_fire     = w_ar_ready & bus.clint_addr_r_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_ar_ready  = 1'b0;
        w_r_valid   = 1'b0;
        unique case (r_state)
            CLINT_IDLE: begin
                w_ar_ready = 1'b1;
                if (bus.clint_addr_r_valid_i) begin
                    w_state_nxt = CLINT_RESP;
                end
            end
            CLINT_RESP: begin
                w_r_valid = 1'b1;
                if (bus.clint_r_ready_i) begin
                    w_state_nxt = CLINT_IDLE;
                end
            end
            default: w_state_nxt = CLINT_IDLE;
        endcase
    end

    // Decode uses mtime as seen on the handshake edge, before its increment.
    always_comb begin
        w_rdata          = '0;
        w_shadow_hi_nxt  = r_shadow_hi;
        w_shadow_vld_nxt = r_shadow_vld;
        if (w_ar_fire) begin
            if (w_off == MTIME_LO_OFF) begin
                w_rdata          = w_mtime[DATA_LEN-1:0];
                w_shadow_hi_nxt  = w_mtime[63:32];
                w_shadow_vld_nxt = 1'b1;
            end else if (w_off == MTIME_HI_OFF) begin
                w_rdata          = r_shadow_vld ? r_shadow_hi : w_mtime[63:32];
                w_shadow_vld_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= CLINT_IDLE;
            r_rdata      <= '0;
            r_shadow_hi  <= '0;
            r_shadow_vld <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow_hi  <= w_shadow_hi_nxt;
            r_shadow_vld <= w_shadow_vld_nxt;
            if (w_ar_fire) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign bus.clint_addr_r_ready_o = w_ar_ready & ~reset;
    assign bus.clint_r_valid_o      = w_r_valid;
    assign bus.clint_r_last_o       = w_r_valid;
    assign bus.clint_r_data_o       = w_r_valid ? r_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060025_clint.sv
// Bench for the CLINT responder: two instances (TICK_DIV 1 and 4), a cycle
// model of mtime/shadow/response, per-cycle compare plus literal checks.
module tb_ysyx_23060025_clint;

    logic clk;
    logic rst;

    ysyx_23060025_clint_if b1 ();
    ysyx_23060025_clint_if b4 ();

    ysyx_23060025_clint #(.TICK_DIV(1)) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (b1)
    );

    ysyx_23060025_clint #(.TICK_DIV(4)) dut4 (
        .clock (clk),
        .reset (rst),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        arv [2];
    logic [31:0] ara [2];
    logic        rr  [2];
    logic        o_rdy [2];
    logic        o_v   [2];
    logic        o_l   [2];
    logic [31:0] o_d   [2];

    assign b1.clint_addr_r_valid_i = arv[0];
    assign b1.clint_addr_r_addr_i  = ara[0];
    assign b1.clint_r_ready_i      = rr[0];
    assign b4.clint_addr_r_valid_i = arv[1];
    assign b4.clint_addr_r_addr_i  = ara[1];
    assign b4.clint_r_ready_i      = rr[1];
    assign o_rdy[0] = b1.clint_addr_r_ready_o;
    assign o_v[0]   = b1.clint_r_valid_o;
    assign o_l[0]   = b1.clint_r_last_o;
    assign o_d[0]   = b1.clint_r_data_o;
    assign o_rdy[1] = b4.clint_addr_r_ready_o;
    assign o_v[1]   = b4.clint_r_valid_o;
    assign o_l[1]   = b4.clint_r_last_o;
    assign o_d[1]   = b4.clint_r_data_o;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: mtime advances once every div(k) cycles since reset release;
    // a response is pending from the accepted address until r_ready.
    logic [63:0] mt   [2];
    int unsigned ec   [2];
    logic        busy [2];
    logic [31:0] rd   [2];
    logic [31:0] sh   [2];
    logic        shv  [2];
    logic [63:0] ld_val [2];
    int          ld_seq [2] = '{0, 0};
    int          ld_ack [2] = '{0, 0};

    function automatic int unsigned div(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [63:0] cur_mt(input int k);
        return (ld_seq[k] != ld_ack[k]) ? ld_val[k] : mt[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            ld_ack[k] <= ld_seq[k];
            if (rst) begin
                mt[k]   <= '0;
                ec[k]   <= 0;
                busy[k] <= 1'b0;
                rd[k]   <= '0;
                sh[k]   <= '0;
                shv[k]  <= 1'b0;
            end else begin
                if (!busy[k] && arv[k]) begin
                    busy[k] <= 1'b1;
                    if (ara[k][15:0] == 16'hBFF8) begin
                        rd[k]  <= cur_mt(k) & 64'hFFFF_FFFF;
                        sh[k]  <= cur_mt(k) >> 32;
                        shv[k] <= 1'b1;
                    end else if (ara[k][15:0] == 16'hBFFC) begin
                        rd[k]  <= shv[k] ? sh[k] : 32'(cur_mt(k) >> 32);
                        shv[k] <= 1'b0;
                    end else begin
                        rd[k] <= '0;
                    end
                end else if (busy[k] && rr[k]) begin
                    busy[k] <= 1'b0;
                end
                ec[k] <= ec[k] + 1;
                if ((ec[k] + 1) % div(k) == 0) mt[k] <= cur_mt(k) + 64'd1;
                else                           mt[k] <= cur_mt(k);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cmp_ready%0d", k), 64'(o_rdy[k]),
                64'(!rst && !busy[k]));
            chk($sformatf("cmp_valid%0d", k), 64'(o_v[k]),
                64'(!rst && busy[k]));
            chk($sformatf("cmp_last%0d", k), 64'(o_l[k]),
                64'(!rst && busy[k]));
            chk($sformatf("cmp_data%0d", k), 64'(o_d[k]),
                (!rst && busy[k]) ? 64'(rd[k]) : 64'd0);
        end
    end

    task automatic rd_op(input int k, input logic [31:0] a,
                         output logic [31:0] d);
        arv[k] = 1'b1;
        ara[k] = a;
        rr[k]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        d = o_d[k];
        chk("rd_valid", 64'(o_v[k]), 64'd1);
        chk("rd_last", 64'(o_l[k]), 64'd1);
        arv[k] = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] d;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            arv[k] = 1'b0;
            ara[k] = '0;
            rr[k]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(o_rdy[0]), 64'd0);
        chk("rst_valid", 64'(o_v[0]), 64'd0);
        #1 rst = 1'b0;

        // Idle 10 cycles, then the lo read sees 10 ticks.
        repeat (10) @(negedge clk);
        rd_op(0, 32'h0200_BFF8, d);
        chk("t1_lo", 64'(d), 64'd10);

        // Tear-free hi after lo across a 32-bit carry.
        force dut1.u_mtime.r_mtime = 64'h0000_0001_FFFF_FFFE;
        release dut1.u_mtime.r_mtime;
        ld_val[0] = 64'h0000_0001_FFFF_FFFE;
        ld_seq[0]++;
        rd_op(0, 32'h0200_BFF8, d);
        chk("t2_lo", 64'(d), 64'hFFFF_FFFE);
        repeat (5) @(negedge clk);
        rd_op(0, 32'h0200_BFFC, d);
        chk("t2_hi_shadow", 64'(d), 64'h1);
        rd_op(0, 32'h0200_BFFC, d);
        chk("t2_hi_live", 64'(d), 64'h2);

        // Unmapped offset leaves the latched shadow intact.
        force dut1.u_mtime.r_mtime = 64'h0000_0007_FFFF_FFFF;
        release dut1.u_mtime.r_mtime;
        ld_val[0] = 64'h0000_0007_FFFF_FFFF;
        ld_seq[0]++;
        rd_op(0, 32'h0200_BFF8, d);
        chk("t5_lo", 64'(d), 64'hFFFF_FFFF);
        rd_op(0, 32'h0200_0000, d);
        chk("t5_unmapped", 64'(d), 64'h0);
        rd_op(0, 32'h0200_BFFC, d);
        chk("t5_hi_shadow", 64'(d), 64'h7);

        // Back-pressure: response held for 20 cycles, new address ignored.
        arv[0] = 1'b1;
        ara[0] = 32'h0200_BFF8;
        rr[0]  = 1'b0;
        @(negedge clk);
        ara[0] = 32'h0200_BFFC;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("t3_hold_ready", 64'(o_rdy[0]), 64'd0);
        end
        arv[0] = 1'b0;
        rr[0]  = 1'b1;
        @(negedge clk);
        #1;
        chk("t3_ready_back", 64'(o_rdy[0]), 64'd1);
        chk("t3_valid_low", 64'(o_v[0]), 64'd0);

        // Fresh reset, then TICK_DIV=4 reads at edges 40 and 80.
        #1 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (39) @(negedge clk);
        rd_op(1, 32'h0200_BFF8, d);
        chk("t4_lo40", 64'(d), 64'd9);
        repeat (38) @(negedge clk);
        rd_op(1, 32'h0200_BFF8, d);
        chk("t4_lo80", 64'(d), 64'd19);
        repeat (3) @(negedge clk);
        force dut4.u_mtime.r_mtime = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut4.u_mtime.r_mtime;
        ld_val[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        ld_seq[1]++;
        repeat (3) @(negedge clk);
        rd_op(1, 32'h0200_BFF8, d);
        chk("t4_pre_wrap", 64'(d), 64'hFFFF_FFFF);
        rd_op(1, 32'h0200_BFF8, d);
        chk("t4_wrapped", 64'(d), 64'h0);
        rd_op(1, 32'h0200_BFFC, d);
        chk("t4_hi_refresh", 64'(d), 64'h0);

        // Reset in the middle of a response drops it at once.
        arv[0] = 1'b1;
        ara[0] = 32'h0200_BFF8;
        rr[0]  = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_valid_pre", 64'(o_v[0]), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid_async", 64'(o_v[0]), 64'd0);
        chk("t6_ready_async", 64'(o_rdy[0]), 64'd0);
        chk("t6_data_async", 64'(o_d[0]), 64'd0);
        arv[0] = 1'b0;
        rr[0]  = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_no_replay", 64'(o_v[0]), 64'd0);
        rd_op(0, 32'h0200_BFF8, d);
        chk("t6_mtime_restart", 64'(d), 64'd1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
